hlsm_sched_mac: RTL and testbench

//   Parametrised HLS-style scheduled datapath: computes j = (a*b + c)*d and k = e*f

---
 rtl/hlsm_pkg.sv | 19 +
 rtl/hlsm_op_timer.sv | 31 +++
 rtl/hlsm_sched_mac.sv | 128 ++++++++++++
 tb/tb_hlsm_sched_mac.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/hlsm_pkg.sv
// Shared state encoding and sizing helper for the scheduled multiply-accumulate HLSM.
package hlsm_pkg;

  typedef enum logic [2:0] {
    sWait  = 3'd0,
    sMul1  = 3'd1,
    sAdd   = 3'd2,
    sMul2  = 3'd3,
    sFinal = 3'd4
  } state_t;

  // Counter must hold the largest operator latency.
  function automatic int cnt_width(input int mul_lat, input int add_lat);
    int m;
    m = (mul_lat > add_lat) ? mul_lat : add_lat;
    return (m + 1 > 2) ? $clog2(m + 1) : 1;
  endfunction

endpackage

// File: rtl/hlsm_op_timer.sv
// Loadable down-counter; expire_o marks the last cycle of an operator's latency window.
module hlsm_op_timer #(
  parameter int CNT_W = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             expire_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign expire_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/hlsm_sched_mac.sv
// Latency-scheduled HLSM computing j = (a*b + c)*d and k = e*f under a Start/Done handshake.
module hlsm_sched_mac
  import hlsm_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int MUL_LAT = 2,
  parameter int ADD_LAT = 1,
  parameter int SIGNED  = 1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  input  logic [DATA_W-1:0] d,
  input  logic [DATA_W-1:0] e,
  input  logic [DATA_W-1:0] f,
  output logic              Done,
  output logic              Busy,
  output logic [DATA_W-1:0] j,
  output logic [DATA_W-1:0] k
);

  localparam int CNT_W = cnt_width(MUL_LAT, ADD_LAT);

  state_t            state_q;
  logic              done_q, busy_q;
  logic [DATA_W-1:0] a_q, b_q, c_q, d_q, e_q, f_q;
  logic [DATA_W-1:0] h_q, i_q, kint_q, j_q, k_q;
  logic              accept, expire, tmr_load;
  logic [CNT_W-1:0]  tmr_val;

  // Full-width product, wrapped to the low DATA_W bits.
  function automatic logic [DATA_W-1:0] mul_trunc(input logic [DATA_W-1:0] x,
                                                   input logic [DATA_W-1:0] y);
    logic signed [2*DATA_W-1:0] ps;
    logic        [2*DATA_W-1:0] pu;
    ps = $signed(x) * $signed(y);
    pu = x * y;
    return (SIGNED != 0) ? DATA_W'(ps) : DATA_W'(pu);
  endfunction

  assign accept = (state_q == sWait) && Start;

  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = CNT_W'(MUL_LAT);
    if (accept) begin
      tmr_load = 1'b1;
    end else if (state_q == sMul1 && expire) begin
      tmr_load = 1'b1;
      tmr_val  = CNT_W'(ADD_LAT);
    end else if (state_q == sAdd && expire) begin
      tmr_load = 1'b1;
    end
  end

  hlsm_op_timer #(.CNT_W(CNT_W)) u_timer (
    .clk_i      (Clk),
    .rst_ni     (Rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .expire_o   (expire)
  );

  always_ff @(posedge Clk) begin
    if (accept) begin
      a_q <= a;
      b_q <= b;
      c_q <= c;
      d_q <= d;
      e_q <= e;
      f_q <= f;
    end
  end

  // Each operator result is registered on the last cycle of its latency window.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= sWait;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      h_q     <= '0;
      i_q     <= '0;
      kint_q  <= '0;
      j_q     <= '0;
      k_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        sWait: if (Start) begin
          state_q <= sMul1;
          busy_q  <= 1'b1;
        end
        sMul1: if (expire) begin
          h_q     <= mul_trunc(a_q, b_q);
          kint_q  <= mul_trunc(e_q, f_q);
          state_q <= sAdd;
        end
        sAdd: if (expire) begin
          i_q     <= h_q + c_q;
          state_q <= sMul2;
        end
        sMul2: if (expire) begin
          j_q     <= mul_trunc(i_q, d_q);
          k_q     <= kint_q;
          done_q  <= 1'b1;
          state_q <= sFinal;
        end
        sFinal: begin
          busy_q  <= 1'b0;
          state_q <= sWait;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= sWait;
        end
      endcase
    end
  end

  assign Done = done_q;
  assign Busy = busy_q;
  assign j    = j_q;
  assign k    = k_q;

endmodule

// File: tb/tb_hlsm_sched_mac.sv
// Bench for hlsm_sched_mac: vector table, random ops against an arithmetic model, corner sequences.
module tb_hlsm_sched_mac;

  localparam int W = 16;

  logic         Clk = 1'b0;
  logic         Rst;
  logic         Start, Start2;
  logic [W-1:0] a, b, c, d, e, f;
  logic [W-1:0] a2, b2, c2, d2, e2, f2;
  logic         Done, Busy, Done2, Busy2;
  logic [W-1:0] j, k, j2, k2;

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  hlsm_sched_mac #(.DATA_W(16), .MUL_LAT(2), .ADD_LAT(1), .SIGNED(1)) u_dut (
    .Clk(Clk), .Rst(Rst), .Start(Start),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f),
    .Done(Done), .Busy(Busy), .j(j), .k(k)
  );

  hlsm_sched_mac #(.DATA_W(16), .MUL_LAT(3), .ADD_LAT(2), .SIGNED(0)) u_dut6 (
    .Clk(Clk), .Rst(Rst), .Start(Start2),
    .a(a2), .b(b2), .c(c2), .d(d2), .e(e2), .f(f2),
    .Done(Done2), .Busy(Busy2), .j(j2), .k(k2)
  );

  typedef struct {
    logic [W-1:0] a, b, c, d, e, f;
    logic [W-1:0] j, k;
  } vec_t;

  vec_t tbl[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Signed reference: wrap the exact integer result to 16 bits.
  function automatic logic [W-1:0] model_j(input logic [W-1:0] xa, xb, xc, xd);
    longint sa, sb, sc, sd;
    sa = longint'($signed(xa));
    sb = longint'($signed(xb));
    sc = longint'($signed(xc));
    sd = longint'($signed(xd));
    return W'((sa * sb + sc) * sd);
  endfunction

  function automatic logic [W-1:0] model_k(input logic [W-1:0] xe, xf);
    return W'(longint'($signed(xe)) * longint'($signed(xf)));
  endfunction

  // One transaction on u_dut; glitch re-pulses Start and corrupts a/b during sAdd.
  task automatic do_op(input vec_t v, input bit glitch, input string tag);
    int n;
    bit busy_ok, done_seen;
    @(negedge Clk);
    a = v.a; b = v.b; c = v.c; d = v.d; e = v.e; f = v.f;
    Start = 1'b1;
    @(posedge Clk);
    #1 Start = 1'b0;
    n = 0;
    busy_ok = 1'b1;
    done_seen = 1'b0;
    while (n < 40 && !done_seen) begin
      @(negedge Clk);
      n++;
      if (Busy !== 1'b1) busy_ok = 1'b0;
      if (Done === 1'b1) done_seen = 1'b1;
      else if (glitch && n == 3) begin
        a = ~v.a;
        b = 16'h1234;
        Start = 1'b1;
      end else if (glitch && n == 4) begin
        Start = 1'b0;
      end
    end
    check({tag, " latency"}, 64'(n), 64'd6);
    check({tag, " busy"}, 64'(busy_ok), 64'd1);
    check({tag, " j"}, 64'(j), 64'(v.j));
    check({tag, " k"}, 64'(k), 64'(v.k));
    @(negedge Clk);
    check({tag, " done width"}, 64'(Done), 64'd0);
    check({tag, " busy low"}, 64'(Busy), 64'd0);
  endtask

  initial begin
    vec_t rv;
    int   prev, pulses, n;
    bit   wide, last_done;

    tbl[0] = '{a:16'd3,    b:16'd4,    c:16'd5,    d:16'd6,    e:16'hFFFE, f:16'd7,
               j:16'h0066, k:16'hFFF2};
    tbl[1] = '{a:16'd256,  b:16'd256,  c:16'd1,    d:16'd1,    e:16'd300,  f:16'd300,
               j:16'h0001, k:16'h5F90};
    tbl[2] = '{a:16'hFFFF, b:16'hFFFF, c:16'hFFFF, d:16'hFFFF, e:16'h8000, f:16'hFFFF,
               j:16'h0000, k:16'h8000};
    tbl[3] = '{a:16'd100,  b:16'd200,  c:16'd50,   d:16'd3,    e:16'hFFF9, f:16'hFFF7,
               j:16'hEAF6, k:16'h003F};
    tbl[4] = '{a:16'd0,    b:16'd0,    c:16'd0,    d:16'd0,    e:16'd0,    f:16'd0,
               j:16'h0000, k:16'h0000};

    Rst = 1'b0; Start = 1'b0; Start2 = 1'b0;
    {a, b, c, d, e, f} = '0;
    {a2, b2, c2, d2, e2, f2} = '0;
    repeat (2) @(negedge Clk);
    check("reset done", 64'(Done), 64'd0);
    check("reset busy", 64'(Busy), 64'd0);
    check("reset j", 64'(j), 64'd0);
    check("reset k", 64'(k), 64'd0);
    check("reset j2", 64'(j2), 64'd0);
    Rst = 1'b1;
    @(negedge Clk);

    for (int i = 0; i < 5; i++) do_op(tbl[i], 1'b0, $sformatf("vec%0d", i));

    // Start/operand changes during sAdd must not disturb the captured transaction.
    do_op(tbl[3], 1'b1, "glitch");

    // Start held high: back-to-back transactions, single-cycle Done pulses.
    @(negedge Clk);
    a = tbl[0].a; b = tbl[0].b; c = tbl[0].c; d = tbl[0].d; e = tbl[0].e; f = tbl[0].f;
    Start = 1'b1;
    prev = -1; pulses = 0; wide = 1'b0; last_done = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge Clk);
      if (Done === 1'b1) begin
        if (last_done) wide = 1'b1;
        if (prev >= 0) check("hold period", 64'(i - prev), 64'd7);
        prev = i;
        pulses++;
      end
      last_done = (Done === 1'b1);
    end
    Start = 1'b0;
    check("hold pulses", 64'(pulses), 64'd4);
    check("hold width", 64'(wide), 64'd0);
    check("hold j", 64'(j), 64'(tbl[0].j));
    n = 0;
    while (Busy !== 1'b0 && n < 20) begin
      @(negedge Clk);
      n++;
    end
    check("hold drain", 64'(Busy), 64'd0);

    // Asynchronous reset in sMul2 aborts immediately.
    @(negedge Clk);
    a = tbl[1].a; b = tbl[1].b; c = tbl[1].c; d = tbl[1].d; e = tbl[1].e; f = tbl[1].f;
    Start = 1'b1;
    @(posedge Clk);
    #1 Start = 1'b0;
    repeat (4) @(negedge Clk);
    check("pre-abort busy", 64'(Busy), 64'd1);
    Rst = 1'b0;
    #1;
    check("abort done", 64'(Done), 64'd0);
    check("abort busy", 64'(Busy), 64'd0);
    check("abort j", 64'(j), 64'd0);
    check("abort k", 64'(k), 64'd0);
    @(negedge Clk);
    Rst = 1'b1;
    do_op(tbl[0], 1'b0, "after abort");

    for (int i = 0; i < 30; i++) begin
      rv.a = W'($urandom); rv.b = W'($urandom); rv.c = W'($urandom);
      rv.d = W'($urandom); rv.e = W'($urandom); rv.f = W'($urandom);
      rv.j = model_j(rv.a, rv.b, rv.c, rv.d);
      rv.k = model_k(rv.e, rv.f);
      do_op(rv, 1'b0, $sformatf("rand%0d", i));
    end

    // Unsigned build with longer operator latencies.
    @(negedge Clk);
    a2 = 16'hFFFF; b2 = 16'd2; c2 = 16'd0; d2 = 16'd1; e2 = 16'h8000; f2 = 16'd3;
    Start2 = 1'b1;
    @(posedge Clk);
    #1 Start2 = 1'b0;
    n = 0;
    while (Done2 !== 1'b1 && n < 40) begin
      @(negedge Clk);
      n++;
    end
    check("lat3 latency", 64'(n), 64'd9);
    check("lat3 j", 64'(j2), 64'hFFFE);
    check("lat3 k", 64'(k2), 64'h8000);
    @(negedge Clk);
    check("lat3 done width", 64'(Done2), 64'd0);
    check("lat3 busy low", 64'(Busy2), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
